// File: rtl/serializer_m_if.sv
// Handshake and serial-output bundle for serializer_m.
// The master drives words and the shift enable; the slave is the serializer.
interface serializer_m_if #(
  parameter int W = 8
);
  logic [W-1:0] d;
  logic         load_valid;
  logic         load_ready;
  logic         enb;
  logic         sout;
  logic         sout_valid;
  logic         done;

  modport master (
    output d, load_valid, enb,
    input  load_ready, sout, sout_valid, done
  );

  modport slave (
    input  d, load_valid, enb,
    output load_ready, sout, sout_valid, done
  );
endinterface

// File: rtl/serializer_m.sv
// Parallel-in/serial-out transmitter with valid/ready load and a done pulse per word.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module serializer_m #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  serializer_m_if.slave  bus
);

  localparam int CNT_W = $clog2(W);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_load;
  logic             w_shift;
  logic             w_done_nxt;
  logic             w_sout_bit;
`ifdef SERIALIZER_PARITY_EN
  logic             r_par;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.enb) begin
          if (r_cnt != '0) begin
            w_shift = 1'b1;
          end else begin
`ifdef SERIALIZER_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: begin
        if (bus.enb) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register: zero fill from the far end so drained bits never reappear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        r_shreg <= bus.d;
        r_cnt   <= CNT_W'(W - 1);
`ifdef SERIALIZER_PARITY_EN
        r_par   <= ^bus.d;
`endif
      end else if (w_shift) begin
        if (MSB_FIRST) begin
          r_shreg <= {r_shreg[W-2:0], 1'b0};
        end else begin
          r_shreg <= {1'b0, r_shreg[W-1:1]};
        end
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Output bit is selected purely from registered state, never from inputs.
  assign w_sout_bit = MSB_FIRST ? r_shreg[W-1] : r_shreg[0];

  always_comb begin
    bus.load_ready = (r_state == S_IDLE);
    bus.sout_valid = (r_state != S_IDLE);
    bus.done       = r_done;
    bus.sout       = 1'b0;
    if (r_state == S_SHIFT) begin
      bus.sout = w_sout_bit;
    end
`ifdef SERIALIZER_PARITY_EN
    if (r_state == S_PARITY) begin
      bus.sout = r_par;
    end
`endif
  end

endmodule

// File: tb/tb_serializer_m.sv
// Directed bench for serializer_m: drives an MSB-first and an LSB-first instance in lockstep.
// Parity expectations follow SERIALIZER_PARITY_EN.
module tb_serializer_m;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d;
  logic         load_valid;
  logic         enb;
  int           n_checks = 0;
  int           n_fail   = 0;

  serializer_m_if #(.W(W)) bus_m ();
  serializer_m_if #(.W(W)) bus_l ();

  assign bus_m.d          = d;
  assign bus_m.load_valid = load_valid;
  assign bus_m.enb        = enb;
  assign bus_l.d          = d;
  assign bus_l.load_valid = load_valid;
  assign bus_l.enb        = enb;

  serializer_m #(.W(W), .MSB_FIRST(1'b1)) u_dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  serializer_m #(.W(W), .MSB_FIRST(1'b0)) u_dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check_eq({tag, " m.sout"},       {31'd0, bus_m.sout},       32'd0);
    check_eq({tag, " m.sout_valid"}, {31'd0, bus_m.sout_valid}, 32'd0);
    check_eq({tag, " m.load_ready"}, {31'd0, bus_m.load_ready}, 32'd1);
    check_eq({tag, " m.done"},       {31'd0, bus_m.done},       {31'd0, exp_done});
    check_eq({tag, " l.sout"},       {31'd0, bus_l.sout},       32'd0);
    check_eq({tag, " l.sout_valid"}, {31'd0, bus_l.sout_valid}, 32'd0);
    check_eq({tag, " l.load_ready"}, {31'd0, bus_l.load_ready}, 32'd1);
    check_eq({tag, " l.done"},       {31'd0, bus_l.done},       {31'd0, exp_done});
  endtask

  task automatic check_bit(input string tag, input logic [W-1:0] w, input int i);
    logic exp_m;
    logic exp_l;
    if (i < W) begin
      exp_m = w[W-1-i];
      exp_l = w[i];
    end else begin
      exp_m = ^w;
      exp_l = ^w;
    end
    check_eq($sformatf("%s m.bit%0d", tag, i), {31'd0, bus_m.sout}, {31'd0, exp_m});
    check_eq($sformatf("%s l.bit%0d", tag, i), {31'd0, bus_l.sout}, {31'd0, exp_l});
    check_eq($sformatf("%s vld%0d", tag, i), {30'd0, bus_m.sout_valid, bus_l.sout_valid}, 32'd3);
    check_eq($sformatf("%s rdy%0d", tag, i), {30'd0, bus_m.load_ready, bus_l.load_ready}, 32'd0);
    check_eq($sformatf("%s done%0d", tag, i), {30'd0, bus_m.done, bus_l.done}, 32'd0);
  endtask

  // Present a word for one edge; returns in cycle 1 of the word.
  task automatic load_word(input logic [W-1:0] w);
    d          = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  // Walk the word from cycle 1; optional stall before bit stall_at; stop_after<0 runs to the done cycle.
  task automatic run_word(input string tag, input logic [W-1:0] w,
                          input int stall_at, input int stall_n, input int stop_after);
    for (int i = 0; i < NB; i++) begin
      if (i == stop_after) return;
      check_bit(tag, w, i);
      if (i == stall_at) begin
        enb = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          step();
          check_bit({tag, " stall"}, w, i);
        end
        enb = 1'b1;
      end
      step();
    end
    check_eq({tag, " done"},  {30'd0, bus_m.done, bus_l.done}, 32'd3);
    check_eq({tag, " ready"}, {30'd0, bus_m.load_ready, bus_l.load_ready}, 32'd3);
    check_eq({tag, " vld_end"}, {30'd0, bus_m.sout_valid, bus_l.sout_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    d          = '0;
    load_valid = 1'b0;
    enb        = 1'b1;

    // Reset and idle
    step();
    check_idle("rst0", 1'b0);
    step();
    check_idle("rst1", 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_idle("idle", 1'b0);
    end

    // Basic word
    load_word(8'hA5);
    run_word("a5", 8'hA5, -1, 0, -1);
    step();
    check_idle("a5_after", 1'b0);

    // Back-to-back: second word accepted on the done cycle
    load_word(8'h0F);
    run_word("0f", 8'h0F, -1, 0, -1);
    load_word(8'hF0);
    run_word("f0", 8'hF0, -1, 0, -1);
    step();
    check_idle("f0_after", 1'b0);

    // Stall after bit 3 with a competing load held high throughout
    load_word(8'hA5);
    d          = 8'hFF;
    load_valid = 1'b1;
    run_word("stall", 8'hA5, 3, 3, -1);
    step();
    load_valid = 1'b0;
    run_word("ff", 8'hFF, -1, 0, -1);
    step();
    check_idle("ff_after", 1'b0);

    // Reset mid-word
    load_word(8'hC3);
    run_word("c3", 8'hC3, -1, 0, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("midrst", 1'b0);
    step();
    check_idle("midrst_nodone", 1'b0);
    load_word(8'h81);
    run_word("81", 8'h81, -1, 0, -1);

    // Second parity case (parity 1); also exercises odd-weight data in the default build
    load_word(8'h07);
    run_word("07", 8'h07, -1, 0, -1);
    step();
    check_idle("end", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
